// File: rtl/tile_addr_gen_pkg.sv
// Shared definitions for the tile address generator and its nested counter.
// Holds the FSM state encoding and the default loop extents.
// The counter instance must be built with the same N*_MAX values as the generator.
package tile_addr_gen_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAN,
        ST_PRIME,
        ST_RUN,
        ST_DRAIN
    } state_t;

    localparam int N0_MAX_DEF = 4;
    localparam int N1_MAX_DEF = 2;
    localparam int N2_MAX_DEF = 2;
    localparam int N3_MAX_DEF = 3;

endpackage

// File: rtl/tile_addr_gen_if.sv
// Address stream toward the tile buffer read port.
// Latency: n/a (wiring only).
// Backpressure: addr/addr_valid/addr_last held by the master while addr_valid & ~addr_ready.
// Ports: addr (AW), addr_valid, addr_last from master; addr_ready from slave.
interface tile_addr_gen_if #(
    parameter int AW = 32
);
    logic [AW-1:0] addr;
    logic          addr_valid;
    logic          addr_ready;
    logic          addr_last;

    modport master (output addr, output addr_valid, output addr_last, input addr_ready);
    modport slave  (input addr, input addr_valid, input addr_last, output addr_ready);
endinterface

// File: rtl/tile_addr_gen_addr_pipe2.sv
// Two-stage multiply-add pipeline turning an index tuple into a linear address.
// Latency: capture edge loads s1, next moving edge loads s2 (addr_valid).
// Backpressure: both stages move only when adv = ~s2_valid | addr_ready.
// Ports: clk, rst; capture/last_in + cnt0..3 + base/strides in; addr_ready in;
//        adv, addr, addr_valid, addr_last out.
module addr_pipe2 #(
    parameter int CW = 16,
    parameter int AW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          capture,
    input  logic          last_in,
    input  logic [CW-1:0] cnt0,
    input  logic [CW-1:0] cnt1,
    input  logic [CW-1:0] cnt2,
    input  logic [CW-1:0] cnt3,
    input  logic [AW-1:0] base,
    input  logic [AW-1:0] stride1,
    input  logic [AW-1:0] stride2,
    input  logic [AW-1:0] stride3,
    input  logic          addr_ready,
    output logic          adv,
    output logic [AW-1:0] addr,
    output logic          addr_valid,
    output logic          addr_last
);

    logic          s1_valid;
    logic          s1_last;
    logic [AW-1:0] p_hi;
    logic [AW-1:0] p_lo;
    logic [AW-1:0] p_hi_n;
    logic [AW-1:0] p_lo_n;

    assign adv = ~addr_valid | addr_ready;

    // Split the sum so each stage carries at most two products.
    always_comb begin
        p_hi_n = AW'(cnt3) * stride3 + AW'(cnt2) * stride2;
        p_lo_n = base + AW'(cnt1) * stride1 + AW'(cnt0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid   <= 1'b0;
            s1_last    <= 1'b0;
            p_hi       <= '0;
            p_lo       <= '0;
            addr       <= '0;
            addr_valid <= 1'b0;
            addr_last  <= 1'b0;
        end else if (adv) begin
            s1_valid <= capture;
            if (capture) begin
                p_hi    <= p_hi_n;
                p_lo    <= p_lo_n;
                s1_last <= last_in;
            end
            addr_valid <= s1_valid;
            // last must fall with valid once the final address has left.
            addr_last  <= s1_valid & s1_last;
            if (s1_valid) begin
                addr <= p_hi + p_lo;
            end
        end
    end

endmodule

// File: rtl/tile_addr_gen.sv
// Read-address generator driving an external 4-level nested counter.
// Latency: first addr_valid 4 edges after the edge sampling start, then one address per clock.
// Backpressure: addr_ready low freezes the pipe and withholds cnt_ena, so the tuple is held.
// Ports: clk, rst, start, base_addr, stride1..3, cnt0..3 in; cnt_ena, cnt_clean, busy, done out;
//        aif (master) carries addr/addr_valid/addr_last/addr_ready.
module tile_addr_gen
    import tile_addr_gen_pkg::*;
#(
    parameter int CW     = 16,
    parameter int AW     = 32,
    parameter int N0_MAX = N0_MAX_DEF,
    parameter int N1_MAX = N1_MAX_DEF,
    parameter int N2_MAX = N2_MAX_DEF,
    parameter int N3_MAX = N3_MAX_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [AW-1:0]       base_addr,
    input  logic [AW-1:0]       stride1,
    input  logic [AW-1:0]       stride2,
    input  logic [AW-1:0]       stride3,
    input  logic [CW-1:0]       cnt0,
    input  logic [CW-1:0]       cnt1,
    input  logic [CW-1:0]       cnt2,
    input  logic [CW-1:0]       cnt3,
    output logic                cnt_ena,
    output logic                cnt_clean,
    output logic                busy,
    output logic                done,
    tile_addr_gen_if.master     aif
);

    state_t        state;
    state_t        state_n;
    logic [AW-1:0] base_q;
    logic [AW-1:0] s1_q;
    logic [AW-1:0] s2_q;
    logic [AW-1:0] s3_q;
    logic          adv;
    logic          capture;
    logic          is_last;
    logic          fin_hs;

    assign is_last = (cnt0 == CW'(N0_MAX - 1)) && (cnt1 == CW'(N1_MAX - 1)) &&
                     (cnt2 == CW'(N2_MAX - 1)) && (cnt3 == CW'(N3_MAX - 1));
    assign fin_hs  = aif.addr_valid & aif.addr_ready & aif.addr_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            base_q <= '0;
            s1_q   <= '0;
            s2_q   <= '0;
            s3_q   <= '0;
        end else begin
            state <= state_n;
            done  <= (state == ST_DRAIN) && fin_hs;
            if (state == ST_IDLE && start) begin
                busy   <= 1'b1;
                base_q <= base_addr;
                s1_q   <= stride1;
                s2_q   <= stride2;
                s3_q   <= stride3;
            end else if (state == ST_DRAIN && fin_hs) begin
                busy <= 1'b0;
            end
        end
    end

    // In RUN the counter advance is tied combinationally to the pipe moving,
    // so a tuple is consumed exactly when it is captured.
    always_comb begin
        state_n   = state;
        cnt_ena   = 1'b0;
        cnt_clean = 1'b0;
        capture   = 1'b0;
        unique case (state)
            ST_IDLE:  if (start) state_n = ST_CLEAN;
            ST_CLEAN: begin
                cnt_clean = 1'b1;
                state_n   = ST_PRIME;
            end
            ST_PRIME: begin
                cnt_ena = 1'b1;
                state_n = ST_RUN;
            end
            ST_RUN: begin
                if (adv) begin
                    capture = 1'b1;
                    if (is_last) state_n = ST_DRAIN;
                    else         cnt_ena = 1'b1;
                end
            end
            ST_DRAIN: if (fin_hs) state_n = ST_IDLE;
            default:  state_n = ST_IDLE;
        endcase
    end

    addr_pipe2 #(.CW(CW), .AW(AW)) u_pipe (
        .clk        (clk),
        .rst        (rst),
        .capture    (capture),
        .last_in    (is_last),
        .cnt0       (cnt0),
        .cnt1       (cnt1),
        .cnt2       (cnt2),
        .cnt3       (cnt3),
        .base       (base_q),
        .stride1    (s1_q),
        .stride2    (s2_q),
        .stride3    (s3_q),
        .addr_ready (aif.addr_ready),
        .adv        (adv),
        .addr       (aif.addr),
        .addr_valid (aif.addr_valid),
        .addr_last  (aif.addr_last)
    );

endmodule

// File: tb/tb_tile_addr_gen.sv
// Directed bench for tile_addr_gen with a behavioural nested counter.
// Latency: n/a.
// Backpressure: addr_ready patterns (always on, stall window, random) driven by the bench.
module tb_tile_addr_gen;
    import tile_addr_gen_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] base_addr = '0;
    logic [31:0] stride1 = '0;
    logic [31:0] stride2 = '0;
    logic [31:0] stride3 = '0;
    logic [15:0] c0 = '0;
    logic [15:0] c1 = '0;
    logic [15:0] c2 = '0;
    logic [15:0] c3 = '0;
    logic        cnt_ena;
    logic        cnt_clean;
    logic        busy;
    logic        done;

    int total = 0;
    int bad   = 0;

    tile_addr_gen_if #(.AW(32)) aif ();

    tile_addr_gen dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .stride1   (stride1),
        .stride2   (stride2),
        .stride3   (stride3),
        .cnt0      (c0),
        .cnt1      (c1),
        .cnt2      (c2),
        .cnt3      (c3),
        .cnt_ena   (cnt_ena),
        .cnt_clean (cnt_clean),
        .busy      (busy),
        .done      (done),
        .aif       (aif)
    );

    always #5 clk = ~clk;

    // Nested counter: idle value is all n_max; enable from idle goes to all zero.
    always @(posedge clk) begin
        if (cnt_clean) begin
            c0 <= 16'(N0_MAX_DEF); c1 <= 16'(N1_MAX_DEF);
            c2 <= 16'(N2_MAX_DEF); c3 <= 16'(N3_MAX_DEF);
        end else if (cnt_ena) begin
            if (c0 == 16'(N0_MAX_DEF)) begin
                c0 <= '0; c1 <= '0; c2 <= '0; c3 <= '0;
            end else if (c0 != 16'(N0_MAX_DEF - 1)) begin
                c0 <= c0 + 16'd1;
            end else begin
                c0 <= '0;
                if (c1 != 16'(N1_MAX_DEF - 1)) c1 <= c1 + 16'd1;
                else begin
                    c1 <= '0;
                    if (c2 != 16'(N2_MAX_DEF - 1)) c2 <= c2 + 16'd1;
                    else begin
                        c2 <= '0;
                        c3 <= c3 + 16'd1;
                    end
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // base=0x100, S1=4, S2=8, S3=16: strides match the linear index, so addr = 0x100 + n.
    // Wrap job: base=0, S3=0xFFFF_FFF0: addr = (n%16) + (n/16)*0xFFFF_FFF0 mod 2^32.
    function automatic logic [31:0] exp_addr(input bit wrap, input int n);
        if (wrap) return 32'(n % 16) + 32'(n / 16) * 32'hFFFF_FFF0;
        return 32'h100 + 32'(n);
    endfunction

    task automatic check_reset_vals(input string tag);
        chk({tag, "_ena"},   cnt_ena, 0);
        chk({tag, "_clean"}, cnt_clean, 0);
        chk({tag, "_valid"}, aif.addr_valid, 0);
        chk({tag, "_last"},  aif.addr_last, 0);
        chk({tag, "_busy"},  busy, 0);
        chk({tag, "_done"},  done, 0);
        chk({tag, "_addr"},  aif.addr, 0);
    endtask

    // mode: 1 ready high, 2 stall at #10, 3 random ready, 4 start while busy, 5 reset after #20
    task automatic run_job(input logic [31:0] b, input logic [31:0] s3v, input int mode, input bit wrap);
        int k = 0;
        int cyc = 0;
        int first_v = -1;
        int first_hs = -1;
        int last_hs = -1;
        int ndone = 0;
        int done_cyc = -1;
        int stall = 0;
        bit prev_stall = 0;
        bit did_rst = 0;
        logic [31:0] prev_addr = '0;
        logic prev_last = 1'b0;
        @(posedge clk); #1;
        base_addr = b; stride1 = 32'd4; stride2 = 32'd8; stride3 = s3v;
        start = 1'b1;
        aif.addr_ready = (mode == 3) ? 1'($urandom_range(0, 1)) : 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        while (cyc < 600) begin
            @(negedge clk);
            if (cyc == 0) chk("busy_after_start", busy, 1);
            if (mode == 1 && cyc == 0) chk("clean_pulse", cnt_clean, 1);
            if (mode == 1 && cyc == 1) chk("prime_ena", cnt_ena, 1);
            if (prev_stall) begin
                chk("stall_addr",  aif.addr, prev_addr);
                chk("stall_valid", aif.addr_valid, 1);
                chk("stall_last",  aif.addr_last, prev_last);
            end
            if (aif.addr_valid && first_v < 0) first_v = cyc;
            if (aif.addr_valid && !aif.addr_ready) chk("stall_cnt_ena", cnt_ena, 0);
            prev_stall = aif.addr_valid & ~aif.addr_ready;
            prev_addr  = aif.addr;
            prev_last  = aif.addr_last;
            if (aif.addr_valid && aif.addr_ready) begin
                chk("addr", aif.addr, exp_addr(wrap, k));
                chk("last", aif.addr_last, (k == 47) ? 1 : 0);
                if (k == 0) first_hs = cyc;
                last_hs = cyc;
                k++;
            end
            if (done) begin
                ndone++;
                done_cyc = cyc;
                chk("busy_at_done", busy, 0);
            end
            if (ndone > 0 && cyc > done_cyc + 3) break;
            @(posedge clk); #1;
            case (mode)
                2: begin
                    if (k == 10 && stall < 5) begin
                        aif.addr_ready = 1'b0;
                        stall++;
                    end else aif.addr_ready = 1'b1;
                end
                3: aif.addr_ready = 1'($urandom_range(0, 1));
                4: begin
                    start = (k < 48) ? 1'b1 : 1'b0;
                    base_addr = 32'hDEAD_0000; stride1 = 32'h55; stride3 = 32'h1234;
                end
                5: begin
                    if (k == 21) begin
                        rst = 1'b1;
                        @(posedge clk); #1;
                        rst = 1'b0;
                        check_reset_vals("mid_rst");
                        did_rst = 1;
                    end
                end
                default: aif.addr_ready = 1'b1;
            endcase
            if (did_rst) break;
            cyc++;
        end
        start = 1'b0;
        if (!did_rst) begin
            chk("addr_count", k, 48);
            chk("done_count", ndone, 1);
            chk("done_timing", done_cyc, last_hs + 1);
            chk("idle_busy", busy, 0);
            chk("idle_valid", aif.addr_valid, 0);
            if (mode == 1) begin
                chk("first_latency", first_v, 4);
                chk("no_gaps", last_hs - first_hs, 47);
            end
            if (mode == 2) chk("stall_len", stall, 5);
        end
    endtask

    initial begin
        aif.addr_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("reset");
        rst = 1'b0;
        run_job(32'h100, 32'd16, 1, 1'b0);
        run_job(32'h100, 32'd16, 2, 1'b0);
        run_job(32'h100, 32'd16, 3, 1'b0);
        run_job(32'h100, 32'd16, 4, 1'b0);
        run_job(32'h100, 32'd16, 5, 1'b0);
        run_job(32'h100, 32'd16, 1, 1'b0);
        run_job(32'h0, 32'hFFFF_FFF0, 1, 1'b1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
